// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for a five-stage MIPS pipeline: load-use, branch-operand
// and mult/div occupancy hazards, plus a saturating stalled-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IRD,
    input  logic [31:0]      IRE,
    input  logic [31:0]      IRM,
    output logic             stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_clr,
    output logic             md_busy,
    output logic [3:0]       md_count,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MD_W  = 4;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OP_W  = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_MFHI  = 6'h10;
    localparam logic [OP_W-1:0] FN_MTHI  = 6'h11;
    localparam logic [OP_W-1:0] FN_MFLO  = 6'h12;
    localparam logic [OP_W-1:0] FN_MTLO  = 6'h13;
    localparam logic [OP_W-1:0] FN_MULT  = 6'h18;
    localparam logic [OP_W-1:0] FN_MULTU = 6'h19;
    localparam logic [OP_W-1:0] FN_DIV   = 6'h1a;
    localparam logic [OP_W-1:0] FN_DIVU  = 6'h1b;

    // Opcode class helpers.
    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    endfunction

    function automatic logic is_ialu(input logic [OP_W-1:0] op);
        return op inside {6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0f};
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op inside {6'h28, 6'h29, 6'h2b};
    endfunction

    function automatic logic is_md(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        return (op == OP_RTYPE) && (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    function automatic logic is_hilo(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
        return (op == OP_RTYPE) && (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    endfunction

    // Destination register; 0 doubles as "no write" since $0 writes are ignored.
    function automatic logic [REG_W-1:0] dest_of(input logic [OP_W-1:0]  op,
                                                 input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd,
                                                 input logic [OP_W-1:0]  fn);
        logic [REG_W-1:0] d;
        d = '0;
        if (is_load(op) || is_ialu(op)) begin
            d = rt;
        end else if (op == OP_RTYPE) begin
            if (!(fn inside {FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO})) begin
                d = rd;
            end
        end else if (op == OP_JAL) begin
            d = 5'd31;
        end
        return d;
    endfunction

    logic [OP_W-1:0]  d_op, d_fn, e_op, e_fn, m_op;
    logic [REG_W-1:0] d_rs, d_rt, e_rt, e_rd, m_rt;

    assign d_op = IRD[31:26];
    assign d_rs = IRD[25:21];
    assign d_rt = IRD[20:16];
    assign d_fn = IRD[5:0];
    assign e_op = IRE[31:26];
    assign e_rt = IRE[20:16];
    assign e_rd = IRE[15:11];
    assign e_fn = IRE[5:0];
    assign m_op = IRM[31:26];
    assign m_rt = IRM[20:16];

    // Fields no hazard rule looks at.
    logic unused_fields;
    assign unused_fields = ^{IRD[15:6], IRE[25:21], IRE[10:6], IRM[25:21], IRM[15:0]};

    logic             d_use_rs, d_use_rt;
    logic             d_br, d_br_rt;
    logic [REG_W-1:0] e_dst;
    logic             e_load, m_load;
    logic             md_start, md_is_mult;
    logic             stall_ld, stall_br, stall_md;
    logic             e_hits_br, m_hits_br;

    // Source registers read by the instruction in D.
    always_comb begin
        d_use_rs = 1'b0;
        d_use_rt = 1'b0;
        if (d_op == OP_RTYPE) begin
            if (d_fn == FN_MFHI || d_fn == FN_MFLO) begin
                d_use_rs = 1'b0;
            end else if (d_fn == FN_JR || d_fn == FN_MTHI || d_fn == FN_MTLO) begin
                d_use_rs = 1'b1;
            end else begin
                d_use_rs = 1'b1;
                d_use_rt = 1'b1;
            end
        end else if (is_load(d_op) || is_ialu(d_op)) begin
            d_use_rs = 1'b1;
        end else if (is_store(d_op) || d_op == OP_BEQ || d_op == OP_BNE) begin
            d_use_rs = 1'b1;
            d_use_rt = 1'b1;
        end
    end

    assign d_br_rt = (d_op == OP_BEQ) || (d_op == OP_BNE);
    assign d_br    = d_br_rt || ((d_op == OP_RTYPE) && (d_fn == FN_JR));

    assign e_dst  = dest_of(e_op, e_rt, e_rd, e_fn);
    assign e_load = is_load(e_op);
    assign m_load = is_load(m_op);

    assign stall_ld = e_load && (e_dst != '0) &&
                      ((d_use_rs && (d_rs == e_dst)) || (d_use_rt && (d_rt == e_dst)));

    // Branch operands are rs always, rt only for beq/bne.
    assign e_hits_br = (e_dst != '0) &&
                       ((d_rs == e_dst) || (d_br_rt && (d_rt == e_dst)));
    assign m_hits_br = m_load && (m_rt != '0) &&
                       ((d_rs == m_rt) || (d_br_rt && (d_rt == m_rt)));
    assign stall_br  = d_br && (e_hits_br || m_hits_br);

    assign md_start   = is_md(e_op, e_fn);
    assign md_is_mult = (e_fn == FN_MULT) || (e_fn == FN_MULTU);
    assign md_busy    = md_start || (md_count != '0);
    assign stall_md   = (is_md(d_op, d_fn) || is_hilo(d_op, d_fn)) && md_busy;

    assign stall    = stall_ld || stall_br || stall_md;
    assign pc_en    = ~stall;
    assign ifid_en  = ~stall;
    assign idex_clr = stall;

    // Mult/div busy countdown; a new start always reloads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_count <= '0;
        end else if (md_start) begin
            md_count <= md_is_mult ? MD_W'(MULT_CYC) : MD_W'(DIV_CYC);
        end else if (md_count != '0) begin
            md_count <= md_count - MD_W'(1);
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed stall, countdown and counter values.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IRD, IRE, IRM;
    logic        stall, pc_en, ifid_en, idex_clr, md_busy;
    logic [3:0]  md_count;
    logic [15:0] stall_cnt;
    logic [3:0]  sat_cnt;
    logic        unused_s_stall, unused_s_pc_en, unused_s_ifid_en, unused_s_idex_clr, unused_s_busy;
    logic [3:0]  unused_s_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .IRD(IRD), .IRE(IRE), .IRM(IRM),
        .stall(stall), .pc_en(pc_en), .ifid_en(ifid_en), .idex_clr(idex_clr),
        .md_busy(md_busy), .md_count(md_count), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .IRD(IRD), .IRE(IRE), .IRM(IRM),
        .stall(unused_s_stall), .pc_en(unused_s_pc_en), .ifid_en(unused_s_ifid_en),
        .idex_clr(unused_s_idex_clr), .md_busy(unused_s_busy), .md_count(unused_s_count),
        .stall_cnt(sat_cnt)
    );

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] i_type(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        IRD = '0; IRE = '0; IRM = '0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_pc_en", 32'(pc_en), 1);
        check("rst_ifid_en", 32'(ifid_en), 1);
        check("rst_idex_clr", 32'(idex_clr), 0);
        check("rst_md_busy", 32'(md_busy), 0);
        check("rst_md_count", 32'(md_count), 0);
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Load-use: lw $8 in E, addu $9,$8,$1 in D
        IRE = i_type(6'h23, 0, 8, 0);
        IRD = r_type(8, 1, 9, 6'h21);
        #1;
        check("lu_stall", 32'(stall), 1);
        check("lu_idex_clr", 32'(idex_clr), 1);
        check("lu_pc_en", 32'(pc_en), 0);
        tick(); exp_cnt++;
        IRM = IRE; IRE = '0;
        #1;
        check("lu_release", 32'(stall), 0);
        check("lu_cnt", 32'(stall_cnt), 32'(exp_cnt));
        IRM = '0;
        IRE = i_type(6'h23, 0, 0, 0);
        IRD = r_type(0, 1, 9, 6'h21);
        #1;
        check("lu_zero_dst", 32'(stall), 0);

        // Branch after load: 2 stall cycles
        tick();
        IRE = i_type(6'h23, 0, 5, 0);
        IRD = i_type(6'h04, 5, 6, 0);
        IRM = '0;
        #1;
        check("bl_stall_e", 32'(stall), 1);
        tick(); exp_cnt++;
        IRM = IRE; IRE = '0;
        #1;
        check("bl_stall_m", 32'(stall), 1);
        tick(); exp_cnt++;
        IRM = '0;
        #1;
        check("bl_release", 32'(stall), 0);
        check("bl_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // Branch after ALU producer: 1 stall cycle
        IRE = i_type(6'h09, 0, 6, 1);
        IRD = i_type(6'h05, 5, 6, 0);
        #1;
        check("ba_stall", 32'(stall), 1);
        tick(); exp_cnt++;
        IRM = IRE; IRE = '0;
        #1;
        check("ba_release", 32'(stall), 0);
        IRM = '0;
        IRE = i_type(6'h09, 0, 7, 1);
        #1;
        check("ba_other_reg", 32'(stall), 0);
        IRD = r_type(7, 0, 0, 6'h08);
        #1;
        check("jr_dep", 32'(stall), 1);
        IRD = r_type(6, 0, 0, 6'h08);
        #1;
        check("jr_nodep", 32'(stall), 0);
        check("ba_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // mult in E with dependent mflo in D: 6 stall cycles
        tick();
        IRE = r_type(1, 2, 0, 6'h18);
        IRD = r_type(0, 0, 3, 6'h12);
        #1;
        check("mul_t_stall", 32'(stall), 1);
        check("mul_t_busy", 32'(md_busy), 1);
        check("mul_t_count", 32'(md_count), 0);
        tick(); exp_cnt++;
        IRE = '0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check($sformatf("mul_count_%0d", i), 32'(md_count), 32'(6 - i));
            check($sformatf("mul_stall_%0d", i), 32'(stall), 1);
            tick(); exp_cnt++;
        end
        #1;
        check("mul_done_count", 32'(md_count), 0);
        check("mul_done_busy", 32'(md_busy), 0);
        check("mul_release", 32'(stall), 0);
        check("mul_cnt", 32'(stall_cnt), 32'(exp_cnt));

        // div: 11 stall cycles
        IRE = r_type(1, 2, 0, 6'h1a);
        #1;
        check("div_t_stall", 32'(stall), 1);
        tick(); exp_cnt++;
        IRE = '0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check($sformatf("div_count_%0d", i), 32'(md_count), 32'(11 - i));
            check($sformatf("div_stall_%0d", i), 32'(stall), 1);
            tick(); exp_cnt++;
        end
        #1;
        check("div_release", 32'(stall), 0);
        check("div_cnt", 32'(stall_cnt), 32'(exp_cnt));
        check("sat_after_21", 32'(sat_cnt), 15);

        // Reset mid-div at md_count = 7, no clock edge in between
        IRD = '0;
        IRE = r_type(1, 2, 0, 6'h1b);
        tick();
        IRE = '0;
        tick();
        tick();
        tick();
        check("rd_pre_count", 32'(md_count), 7);
        check("rd_pre_cnt", 32'(stall_cnt), 32'(exp_cnt));
        #1;
        reset = 1'b1;
        #1;
        check("rd_count", 32'(md_count), 0);
        check("rd_busy", 32'(md_busy), 0);
        check("rd_cnt", 32'(stall_cnt), 0);
        check("rd_sat_cnt", 32'(sat_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;

        // Held load-use hazard for 20 cycles: 4-bit counter saturates at 15
        IRE = i_type(6'h23, 0, 8, 0);
        IRD = r_type(8, 1, 9, 6'h21);
        for (int i = 0; i < 14; i++) tick();
        check("sat_14", 32'(sat_cnt), 14);
        check("wide_14", 32'(stall_cnt), 14);
        for (int i = 0; i < 6; i++) tick();
        check("sat_20", 32'(sat_cnt), 15);
        check("wide_20", 32'(stall_cnt), 20);

        IRD = '0; IRE = '0; IRM = '0;
        #1;
        check("final_idle", 32'(stall), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
